// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between execute and the data-memory port.
// Accepts one memory op at a time. Traps undefined ops and misaligned
// accesses without touching the bus. Otherwise it drives a req/gnt/rvalid
// bus with lane-aligned byte enables and store data, and returns
// sign-/zero-extended load data to writeback.
//
// Ports
//   clk_i, rst_ni             clock, synchronous active-low reset
//   valid_i / ready_o         op handshake (ready_o high in IDLE)
//   load_sel_i, store_sel_i   op type (exactly one must be set)
//   load_op_i, store_op_i     width/sign encodings (funct3 style)
//   rd_addr_i                 load destination register
//   addr_i, wdata_i           effective byte address, rs2 store data
//   dmem_*                    data-memory bus (outputs registered)
//   wb_valid_o/wb_rd_o/wb_data_o  load writeback (1-cycle pulse)
//   store_done_o              store granted (1-cycle pulse)
//   misaligned_o, illegal_o   trap pulses

package lsu_pkg;
  typedef logic [2:0] load_op_t;
  typedef logic [2:0] store_op_t;
  typedef logic [4:0] register_file_t;

  localparam load_op_t  LD_B  = 3'b000;
  localparam load_op_t  LD_H  = 3'b001;
  localparam load_op_t  LD_W  = 3'b010;
  localparam load_op_t  LD_BU = 3'b100;
  localparam load_op_t  LD_HU = 3'b101;

  localparam store_op_t ST_B  = 3'b000;
  localparam store_op_t ST_H  = 3'b001;
  localparam store_op_t ST_W  = 3'b010;

  typedef struct packed {
    logic           load_sel;
    logic           store_sel;
    load_op_t       load_op;
    store_op_t      store_op;
    register_file_t rd_addr;
  } core_ctrl_t;
endpackage

module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               load_sel_i,
  input  logic               store_sel_i,
  input  load_op_t           load_op_i,
  input  store_op_t          store_op_i,
  input  register_file_t     rd_addr_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic               dmem_req_o,
  input  logic               dmem_gnt_i,
  output logic               dmem_we_o,
  output logic [3:0]         dmem_be_o,
  output logic [ADDR_W-1:0]  dmem_addr_o,
  output logic [DATA_W-1:0]  dmem_wdata_o,
  input  logic               dmem_rvalid_i,
  input  logic [DATA_W-1:0]  dmem_rdata_i,
  output logic               wb_valid_o,
  output register_file_t     wb_rd_o,
  output logic [DATA_W-1:0]  wb_data_o,
  output logic               store_done_o,
  output logic               misaligned_o,
  output logic               illegal_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t         st;
  load_op_t       op_q;
  logic [1:0]     off_q;
  register_file_t rd_q;

  assign ready_o = (st == IDLE);

  // ---- accept-side decode ----
  // sz: 00 byte, 01 half, 10 word (low two bits of either op encoding)
  logic [1:0]      sz;
  logic            op_undef, sel_bad, misal;
  logic [3:0]      be_c;
  logic [3:0][7:0] wdata_c;
  logic [3:0][7:0] wsrc;

  assign wsrc = wdata_i;

  always_comb begin
    sz       = load_sel_i ? load_op_i[1:0] : store_op_i[1:0];
    sel_bad  = (load_sel_i == store_sel_i);
    op_undef = load_sel_i ? (load_op_i inside {3'b011, 3'b110, 3'b111})
                          : (store_op_i >= 3'b011);
    misal    = ((sz == 2'b01) && addr_i[0]) ||
               ((sz == 2'b10) && (addr_i[1:0] != 2'b00));
    case (sz)
      2'b00:   be_c = 4'b0001 << addr_i[1:0];
      2'b01:   be_c = addr_i[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
  end

  // Each lane picks its store byte: replicated byte, replicated half, or
  // straight pass-through, so the bus sees the data on whatever lane be marks.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    always_comb begin
      case (sz)
        2'b00:   wdata_c[l] = wsrc[0];
        2'b01:   wdata_c[l] = wsrc[l % 2];
        default: wdata_c[l] = wsrc[l];
      endcase
    end
  end

  // ---- load-side extraction ----
  logic [3:0][7:0]   rd_b;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_res;

  assign rd_b = dmem_rdata_i;

  always_comb begin
    ld_byte = rd_b[off_q];
    ld_half = off_q[1] ? {rd_b[3], rd_b[2]} : {rd_b[1], rd_b[0]};
    case (op_q)
      LD_B:    ld_res = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   ld_res = {24'h0, ld_byte};
      LD_H:    ld_res = {{16{ld_half[15]}}, ld_half};
      LD_HU:   ld_res = {16'h0, ld_half};
      default: ld_res = dmem_rdata_i;
    endcase
  end

  // ---- FSM with registered outputs ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st           <= IDLE;
      op_q         <= LD_B;
      off_q        <= 2'b00;
      rd_q         <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_be_o    <= 4'b0000;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      store_done_o <= 1'b0;
      misaligned_o <= 1'b0;
      illegal_o    <= 1'b0;
    end else begin
      wb_valid_o   <= 1'b0;
      store_done_o <= 1'b0;
      misaligned_o <= 1'b0;
      illegal_o    <= 1'b0;
      case (st)
        IDLE: begin
          if (valid_i) begin
            if (sel_bad || op_undef) begin
              illegal_o <= 1'b1;
            end else if (misal) begin
              misaligned_o <= 1'b1;
            end else begin
              op_q         <= load_op_i;
              off_q        <= addr_i[1:0];
              rd_q         <= rd_addr_i;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= store_sel_i;
              dmem_be_o    <= be_c;
              dmem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
              dmem_wdata_o <= wdata_c;
              st           <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            if (dmem_we_o) begin
              store_done_o <= 1'b1;
              st           <= IDLE;
            end else begin
              st <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (dmem_rvalid_i) begin
            wb_data_o  <= ld_res;
            wb_rd_o    <= rd_q;
            // x0 loads still hit the bus but never write back
            wb_valid_o <= (rd_q != '0);
            st         <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expected bus beats, writebacks, store-done
// and trap pulses are queued when ops are issued and popped by a negedge
// monitor when the DUT produces them. Drivers add cycle-exact checks.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           valid_i = 1'b0;
  logic           ready_o;
  logic           load_sel_i = 1'b0, store_sel_i = 1'b0;
  load_op_t       load_op_i = '0;
  store_op_t      store_op_i = '0;
  register_file_t rd_addr_i = '0;
  logic [31:0]    addr_i = '0, wdata_i = '0;
  logic           dmem_req_o, dmem_gnt_i = 1'b0, dmem_we_o;
  logic [3:0]     dmem_be_o;
  logic [31:0]    dmem_addr_o, dmem_wdata_o;
  logic           dmem_rvalid_i = 1'b0;
  logic [31:0]    dmem_rdata_i = '0;
  logic           wb_valid_o;
  register_file_t wb_rd_o;
  logic [31:0]    wb_data_o;
  logic           store_done_o, misaligned_o, illegal_o;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .load_sel_i(load_sel_i), .store_sel_i(store_sel_i),
    .load_op_i(load_op_i), .store_op_i(store_op_i), .rd_addr_i(rd_addr_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o),
    .dmem_be_o(dmem_be_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .store_done_o(store_done_o),
    .misaligned_o(misaligned_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int nchk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  localparam int K_BUS = 1, K_WB = 2, K_DONE = 3, K_MIS = 4, K_ILL = 5;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];

  task automatic push(input int kind, input logic [31:0] addr, input logic [3:0] be,
                      input logic we, input logic [31:0] wd, input logic [4:0] rd,
                      input logic [31:0] data);
    exp_t e;
    e.kind = kind; e.addr = addr; e.be = be; e.we = we; e.wd = wd; e.rd = rd; e.data = data;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", kind, 0);
    end else begin
      e = q.pop_front();
      chk("sb_kind", kind, e.kind);
      if (kind == K_BUS && e.kind == K_BUS) begin
        chk("sb_addr", dmem_addr_o, e.addr);
        chk("sb_be", {28'h0, dmem_be_o}, {28'h0, e.be});
        chk("sb_we", {31'h0, dmem_we_o}, {31'h0, e.we});
        if (e.we) chk("sb_wdata", dmem_wdata_o, e.wd);
      end
      if (kind == K_WB && e.kind == K_WB) begin
        chk("sb_wb_rd", {27'h0, wb_rd_o}, {27'h0, e.rd});
        chk("sb_wb_data", wb_data_o, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni) begin
      if (dmem_req_o && dmem_gnt_i) pop_cmp(K_BUS);
      if (wb_valid_o)   pop_cmp(K_WB);
      if (store_done_o) pop_cmp(K_DONE);
      if (misaligned_o) pop_cmp(K_MIS);
      if (illegal_o)    pop_cmp(K_ILL);
    end
  end

  // ---- reference model ----
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd0) return 4'b0001 << off;
    if (sz == 2'd1) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return {4{w[7:0]}};
    if (sz == 2'd1) return {2{w[15:0]}};
    return w;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] op, input logic [1:0] off,
                                       input logic [31:0] r);
    logic [31:0] sh;
    sh = r >> (8 * off);
    case (op)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return r;
    endcase
  endfunction

  // ---- drivers (all drive at posedge+1) ----
  task automatic issue(input logic ld, input logic st, input logic [2:0] lop,
                       input logic [2:0] sop, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] w);
    chk("ready_before_issue", {31'h0, ready_o}, 32'd1);
    valid_i = 1'b1; load_sel_i = ld; store_sel_i = st; load_op_i = lop;
    store_op_i = sop; rd_addr_i = rd; addr_i = a; wdata_i = w;
    @(posedge clk); #1;
    valid_i = 1'b0; addr_i = 32'hFFFF_FFFF; wdata_i = 32'h5555_5555;
  endtask

  task automatic do_store(input logic [2:0] sop, input logic [31:0] a,
                          input logic [31:0] w, input int gwait);
    int reqcyc = 0;
    push(K_BUS, {a[31:2], 2'b00}, m_be(sop[1:0], a[1:0]), 1'b1, m_wd(sop[1:0], w), 5'd0, 32'd0);
    push(K_DONE, 0, 0, 0, 0, 0, 0);
    issue(1'b0, 1'b1, 3'b000, sop, 5'd0, a, w);
    for (int i = 0; i < gwait; i++) begin
      if (dmem_req_o) reqcyc++;
      chk("st_stall_addr", dmem_addr_o, {a[31:2], 2'b00});
      chk("st_stall_done", {31'h0, store_done_o}, 32'd0);
      @(posedge clk); #1;
    end
    if (dmem_req_o) reqcyc++;
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    chk("st_req_cycles", reqcyc, gwait + 1);
    chk("st_done", {31'h0, store_done_o}, 32'd1);
    chk("st_ready", {31'h0, ready_o}, 32'd1);
    chk("st_req_drop", {31'h0, dmem_req_o}, 32'd0);
  endtask

  task automatic do_load(input logic [2:0] lop, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] r, input int gwait, input int rwait);
    push(K_BUS, {a[31:2], 2'b00}, m_be(lop[1:0], a[1:0]), 1'b0, 32'd0, 5'd0, 32'd0);
    if (rd != 5'd0) push(K_WB, 0, 0, 0, 0, rd, m_ld(lop, a[1:0], r));
    issue(1'b1, 1'b0, lop, 3'b000, rd, a, 32'd0);
    for (int i = 0; i < gwait; i++) begin
      // rvalid while still in REQ must be ignored
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBAD0_BAD0;
      chk("ld_stall_req", {31'h0, dmem_req_o}, 32'd1);
      @(posedge clk); #1;
    end
    dmem_rvalid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    for (int j = 0; j < rwait; j++) begin
      chk("ld_wait_ready", {31'h0, ready_o}, 32'd0);
      @(posedge clk); #1;
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = r;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    chk("ld_wb_valid", {31'h0, wb_valid_o}, {31'h0, (rd != 5'd0)});
    chk("ld_ready", {31'h0, ready_o}, 32'd1);
    if (rd != 5'd0) chk("ld_wb_data", wb_data_o, m_ld(lop, a[1:0], r));
  endtask

  task automatic do_trap(input logic ld, input logic st, input logic [2:0] lop,
                         input logic [2:0] sop, input logic [31:0] a, input int kind);
    push(kind, 0, 0, 0, 0, 0, 0);
    issue(ld, st, lop, sop, 5'd7, a, 32'h1234_5678);
    chk("trap_mis", {31'h0, misaligned_o}, {31'h0, (kind == K_MIS)});
    chk("trap_ill", {31'h0, illegal_o}, {31'h0, (kind == K_ILL)});
    chk("trap_no_req", {31'h0, dmem_req_o}, 32'd0);
    chk("trap_ready", {31'h0, ready_o}, 32'd1);
    @(posedge clk); #1;
    chk("trap_pulse_end", {31'h0, misaligned_o | illegal_o}, 32'd0);
    chk("trap_no_req2", {31'h0, dmem_req_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, ready_o}, 32'd1);
    chk("rst_req", {31'h0, dmem_req_o}, 32'd0);
    chk("rst_wb_valid", {31'h0, wb_valid_o}, 32'd0);
    chk("rst_wb_rd", {27'h0, wb_rd_o}, 32'd0);
    chk("rst_pulses", {28'h0, store_done_o, misaligned_o, illegal_o, dmem_we_o}, 32'd0);
    chk("rst_be", {28'h0, dmem_be_o}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // SW with a 2-cycle grant stall, then SB straight after
    do_store(ST_W, 32'h0000_1004, 32'hDEAD_BEEF, 2);
    do_store(ST_B, 32'h0000_2003, 32'h0000_00A5, 0);
    do_store(ST_H, 32'h0000_2006, 32'h0000_C3D2, 1);

    // LB vs LBU, then a few more widths
    do_load(LD_B,  5'd5, 32'h0000_3002, 32'h1280_FF00, 0, 0);
    chk("lb_wb_rd", {27'h0, wb_rd_o}, 32'd5);
    @(posedge clk); #1;
    chk("lb_wb_one_cycle", {31'h0, wb_valid_o}, 32'd0);
    do_load(LD_BU, 5'd5, 32'h0000_3002, 32'h1280_FF00, 0, 0);
    do_load(LD_H,  5'd9, 32'h0000_3002, 32'h8001_7FFF, 2, 3);
    do_load(LD_HU, 5'd10, 32'h0000_3000, 32'h1234_9ABC, 0, 1);
    do_load(LD_W,  5'd31, 32'h0000_4008, 32'hCAFE_F00D, 1, 0);

    // traps
    do_trap(1'b1, 1'b0, LD_H, 3'b000, 32'h0000_3001, K_MIS);
    do_trap(1'b0, 1'b1, 3'b000, ST_W, 32'h0000_3002, K_MIS);
    do_trap(1'b1, 1'b1, LD_W, ST_W, 32'h0000_3000, K_ILL);
    do_trap(1'b1, 1'b0, 3'b111, 3'b000, 32'h0000_3000, K_ILL);
    do_trap(1'b0, 1'b1, 3'b000, 3'b011, 32'h0000_3000, K_ILL);
    do_trap(1'b0, 1'b0, 3'b000, 3'b000, 32'h0000_3000, K_ILL);

    // reset while in WAIT_R; late rvalid must be ignored
    push(K_BUS, 32'h0000_5000, 4'b1111, 1'b0, 32'd0, 5'd0, 32'd0);
    issue(1'b1, 1'b0, LD_W, 3'b000, 5'd3, 32'h0000_5000, 32'd0);
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    chk("pre_rst_waitr", {31'h0, ready_o}, 32'd0);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    chk("mid_rst_ready", {31'h0, ready_o}, 32'd1);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    chk("late_rvalid_wb", {31'h0, wb_valid_o}, 32'd0);
    chk("late_rvalid_ready", {31'h0, ready_o}, 32'd1);

    // reset while in REQ drops the request
    push(K_DONE, 0, 0, 0, 0, 0, 0);  // never produced; removed below
    void'(q.pop_back());
    issue(1'b0, 1'b1, 3'b000, ST_W, 5'd0, 32'h0000_6000, 32'h0);
    chk("req_before_rst", {31'h0, dmem_req_o}, 32'd1);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    chk("req_after_rst", {31'h0, dmem_req_o}, 32'd0);
    chk("ready_after_rst", {31'h0, ready_o}, 32'd1);
    @(posedge clk); #1;
    chk("no_done_after_rst", {31'h0, store_done_o}, 32'd0);

    // LW to x0: bus access happens, no writeback
    do_load(LD_W, 5'd0, 32'h0000_7000, 32'h7777_7777, 0, 0);

    repeat (2) @(posedge clk); #1;
    chk("sb_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the execute stage and the data-memory port. Accepts one memory operation at a time, described by the decoded `load_sel`/`store_sel`, `load_op_t`/`store_op_t` and `rd_addr` fields of `core_ctrl_t`. Drives a req/gnt/rvalid data bus with lane-aligned byte enables and write data, and returns sign- or zero-extended load results to writeback. Misaligned and undefined operations are trapped without a bus access.

## Interface
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: bus and register width. Only 32 is supported.

- `clk_i`  in  1  core clock
- `rst_ni`  in  1  synchronous reset, active-low
- `valid_i`  in  1  execute stage presents a memory op
- `ready_o`  out  1  high in IDLE; op accepted when `valid_i & ready_o`
- `load_sel_i` / `store_sel_i`  in  1 / 1  operation type
- `load_op_i`  in  `load_op_t`  load width and sign
- `store_op_i`  in  `store_op_t`  store width
- `rd_addr_i`  in  `register_file_t`  load destination
- `addr_i`  in  ADDR_W  effective byte address
- `wdata_i`  in  DATA_W  rs2 store data
- `dmem_req_o`  out  1  bus request
- `dmem_gnt_i`  in  1  request accepted
- `dmem_we_o`  out  1  1 = store
- `dmem_be_o`  out  4  byte enables
- `dmem_addr_o`  out  ADDR_W  word-aligned address
- `dmem_wdata_o`  out  DATA_W  lane-aligned store data
- `dmem_rvalid_i`  in  1  read data valid
- `dmem_rdata_i`  in  DATA_W  read data
- `wb_valid_o`  out  1  load result valid (1-cycle pulse)
- `wb_rd_o`  out  `register_file_t`  load destination
- `wb_data_o`  out  DATA_W  extended load result
- `store_done_o`  out  1  store granted (1-cycle pulse)
- `misaligned_o`  out  1  alignment trap (1-cycle pulse)
- `illegal_o`  out  1  undefined-op trap (1-cycle pulse)

## Operation
- FSM states: IDLE, REQ, WAIT_R. Reset enters IDLE.
- **IDLE, accept:** on `valid_i` the op is checked in this order:
  - `load_sel_i == store_sel_i`: `illegal_o` next cycle, remain IDLE.
  - Undefined `load_op` (011, 110, 111) or `store_op` (≥ 011): `illegal_o` next cycle, remain IDLE.
  - Misalignment: halfword with `addr[0]=1`, or word with `addr[1:0]≠0`. `misaligned_o` next cycle, remain IDLE, no bus access.
  - Otherwise register the op, byte offset, `rd`, be and wdata, and go to REQ.
- **Byte enables:**
  - byte: `be = 1 << addr[1:0]`
  - half: `0011` or `1100` by `addr[1]`
  - word: `1111`
- **Store data:**
  - SB replicates `wdata[7:0]` into all four lanes.
  - SH replicates `wdata[15:0]` into both halves.
  - SW passes `wdata` through.
- `dmem_addr_o = {addr[ADDR_W-1:2], 2'b00}`.
- **REQ:** `dmem_req_o=1`. Address, be, we and wdata are held stable until `dmem_gnt_i`.
  - On gnt with a store: `store_done_o` pulse next cycle, go to IDLE.
  - On gnt with a load: go to WAIT_R.
- **WAIT_R:** on `dmem_rvalid_i`:
  - Select the lane by the registered offset.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Register `wb_data_o` and `wb_rd_o`, pulse `wb_valid_o`, go to IDLE.
- `rd == x0`: the load is still performed, but `wb_valid_o` is suppressed.
- `dmem_rvalid_i` in IDLE or REQ is ignored. The bus guarantees rvalid no earlier than the cycle after gnt.

## Timing
- **Reset values:** all outputs 0 except `ready_o=1` (IDLE). `wb_rd_o=x0`.
- Bus outputs are registered. `ready_o` is decoded from state.
- **Store, gnt in first REQ cycle:** accept at cycle N, `dmem_req_o` at N+1, `store_done_o` and `ready_o` at N+2.
- **Load, gnt at N+1, rvalid at N+2:** `wb_valid_o` at N+3, `ready_o` at N+3.
- gnt stalls of any length hold REQ. rvalid delays of any length hold WAIT_R. There is no timeout.
- Trap pulses appear at N+1; `ready_o` stays high throughout.
- **Reset mid-operation:** the next edge returns to IDLE and drops `dmem_req_o`. A late rvalid after reset is ignored, and no wb or done pulse is produced.
- Back-to-back: the next op can be accepted in the same cycle `ready_o` returns high.

## Test plan
- **SW:** `addr=0x1004`, `wdata=0xDEADBEEF`, gnt after 2 wait cycles. Expect req held 3 cycles with addr `0x1004`, be `1111`, we 1, wdata `0xDEADBEEF`, then one `store_done_o`.
- **SB:** `addr=0x2003`, `wdata=0x000000A5`. Expect be `1000`, wdata `0xA5A5A5A5`, addr `0x2000`.
- **LB vs LBU:** `addr=0x3002`, rdata `0x1280FF00`, `rd=x5`. Expect LB → `wb_data_o=0xFFFFFF80`; LBU → `0x00000080`; `wb_rd_o=x5`; wb exactly 1 cycle after rvalid.
- **LH:** `addr=0x3001`. Expect `misaligned_o` pulse, no `dmem_req_o`, `ready_o` stays 1.
- **Illegal ops:** `load_sel=store_sel=1` → `illegal_o`. `load_op=3'b111` → `illegal_o`. No bus activity in either case.
- **Reset and x0:** deassert `rst_ni` in WAIT_R, then rvalid arrives → no `wb_valid_o`, state IDLE. LW to `x0` with rvalid → no `wb_valid_o`, `ready_o` returns.
